// File: rtl/tlb_req_ctrl.sv
// Shared TLB front end: round-robin over fetch/data ports, lookup, page walk, insert, flush.
// Optional counters (stat_hits/misses/faults) when TLB_REQ_CTRL_STATS_EN is defined.
module tlb_req_ctrl #(
   parameter int SADDR   = 64,
   parameter int SPAGE   = 12,
   parameter int SPCID   = 12,
   parameter int TIMEOUT = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [1:0]         req_valid,
   input  logic [2*SADDR-1:0] req_va,
   input  logic [2*SPCID-1:0] req_pcid,
   output logic [1:0]         req_ready,
   output logic               rsp_valid,
   output logic               rsp_id,
   output logic [SADDR-1:0]   rsp_ta,
   output logic               rsp_fault,
   input  logic               flush_req,
   output logic               flush_done,
   output logic               walk_req,
   output logic [SADDR-1:0]   walk_va,
   output logic [SPCID-1:0]   walk_pcid,
   input  logic               walk_ack,
   input  logic [SADDR-1:0]   walk_pa,
   input  logic               walk_fault,
   output logic [SADDR-1:0]   tlb_va,
   output logic [SPCID-1:0]   tlb_pcid,
   output logic [SADDR-1:0]   tlb_pa,
   output logic               tlb_insert,
   output logic               tlb_shutdown,
   input  logic               tlb_hit,
   input  logic               tlb_miss,
   input  logic [SADDR-1:0]   tlb_ta
`ifdef TLB_REQ_CTRL_STATS_EN
  ,output logic [31:0]        stat_hits,
   output logic [31:0]        stat_misses,
   output logic [31:0]        stat_faults
`endif
);

   localparam int SVPN = SADDR - SPAGE;
   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_LOOKUP = 3'd1;
   localparam logic [2:0] S_WALK   = 3'd2;
   localparam logic [2:0] S_INSERT = 3'd3;
   localparam logic [2:0] S_FLUSH  = 3'd4;
   localparam logic [2:0] S_FWAIT  = 3'd5;
   localparam logic [3:0] TO_LAST  = 4'(TIMEOUT - 1);

   logic [2:0]       state_q, state_d;
   logic [3:0]       cnt_q, cnt_d;
   logic             last_q, last_d;
   logic             id_q, id_d;
   logic [SADDR-1:0] va_q, va_d;
   logic [SPCID-1:0] pcid_q, pcid_d;
   logic [SADDR-1:0] tva_q, tva_d;
   logic [SPCID-1:0] tpcid_q, tpcid_d;
   logic [SADDR-1:0] tpa_q, tpa_d;
   logic             ltr_v_q, ltr_v_d;
   logic [SVPN-1:0]  ltr_vpn_q, ltr_vpn_d;
   logic [SVPN-1:0]  ltr_ppn_q, ltr_ppn_d;
   logic [SPCID-1:0] ltr_pcid_q, ltr_pcid_d;
   logic             rv_q, rv_d;
   logic             rid_q, rid_d;
   logic [SADDR-1:0] rta_q, rta_d;
   logic             rf_q, rf_d;

   logic             sel;
   logic             grant;
   logic             ltr_hit;
   logic [SADDR-1:0] in_va;
   logic [SPCID-1:0] in_pcid;

   assign sel     = (&req_valid) ? ~last_q : req_valid[1];
   assign in_va   = sel ? req_va[2*SADDR-1:SADDR] : req_va[SADDR-1:0];
   assign in_pcid = sel ? req_pcid[2*SPCID-1:SPCID] : req_pcid[SPCID-1:0];
   assign grant   = (state_q == S_IDLE) && !flush_req && (|req_valid);
   // The TLB ignores an unchanged va/pcid, so repeats are served locally
   assign ltr_hit = grant && ltr_v_q &&
                    (in_va[SADDR-1:SPAGE] == ltr_vpn_q) &&
                    (in_pcid == ltr_pcid_q);

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      last_d     = last_q;
      id_d       = id_q;
      va_d       = va_q;
      pcid_d     = pcid_q;
      tva_d      = tva_q;
      tpcid_d    = tpcid_q;
      tpa_d      = tpa_q;
      ltr_v_d    = ltr_v_q;
      ltr_vpn_d  = ltr_vpn_q;
      ltr_ppn_d  = ltr_ppn_q;
      ltr_pcid_d = ltr_pcid_q;
      rv_d       = 1'b0;
      rid_d      = rid_q;
      rta_d      = rta_q;
      rf_d       = rf_q;
      case (state_q)
         S_IDLE: begin
            if (flush_req) begin
               state_d = S_FLUSH;
               cnt_d   = '0;
               ltr_v_d = 1'b0;
            end else if (grant) begin
               last_d = sel;
               id_d   = sel;
               va_d   = in_va;
               pcid_d = in_pcid;
               if (ltr_hit) begin
                  rv_d  = 1'b1;
                  rid_d = sel;
                  rta_d = {ltr_ppn_q, in_va[SPAGE-1:0]};
                  rf_d  = 1'b0;
               end else begin
                  tva_d   = in_va;
                  tpcid_d = in_pcid;
                  cnt_d   = '0;
                  state_d = S_LOOKUP;
               end
            end
         end
         S_LOOKUP: begin
            if (tlb_hit) begin
               rv_d       = 1'b1;
               rid_d      = id_q;
               rta_d      = tlb_ta;
               rf_d       = 1'b0;
               ltr_v_d    = 1'b1;
               ltr_vpn_d  = va_q[SADDR-1:SPAGE];
               ltr_ppn_d  = tlb_ta[SADDR-1:SPAGE];
               ltr_pcid_d = pcid_q;
               state_d    = S_IDLE;
            end else if (tlb_miss || cnt_q == TO_LAST) begin
               state_d = S_WALK;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         S_WALK: begin
            if (walk_ack) begin
               if (walk_fault) begin
                  rv_d    = 1'b1;
                  rid_d   = id_q;
                  rta_d   = '0;
                  rf_d    = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  tpa_d   = walk_pa;
                  cnt_d   = '0;
                  state_d = S_INSERT;
               end
            end
         end
         S_INSERT: begin
            if (cnt_q == 4'd1) begin
               rv_d       = 1'b1;
               rid_d      = id_q;
               rta_d      = {tpa_q[SADDR-1:SPAGE], va_q[SPAGE-1:0]};
               rf_d       = 1'b0;
               ltr_v_d    = 1'b1;
               ltr_vpn_d  = va_q[SADDR-1:SPAGE];
               ltr_ppn_d  = tpa_q[SADDR-1:SPAGE];
               ltr_pcid_d = pcid_q;
               state_d    = S_IDLE;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         S_FLUSH: begin
            if (cnt_q == 4'd1) state_d = S_FWAIT;
            else cnt_d = cnt_q + 4'd1;
         end
         S_FWAIT: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         last_q     <= 1'b1;
         id_q       <= 1'b0;
         va_q       <= '0;
         pcid_q     <= '0;
         tva_q      <= '0;
         tpcid_q    <= '0;
         tpa_q      <= '0;
         ltr_v_q    <= 1'b0;
         ltr_vpn_q  <= '0;
         ltr_ppn_q  <= '0;
         ltr_pcid_q <= '0;
         rv_q       <= 1'b0;
         rid_q      <= 1'b0;
         rta_q      <= '0;
         rf_q       <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         last_q     <= last_d;
         id_q       <= id_d;
         va_q       <= va_d;
         pcid_q     <= pcid_d;
         tva_q      <= tva_d;
         tpcid_q    <= tpcid_d;
         tpa_q      <= tpa_d;
         ltr_v_q    <= ltr_v_d;
         ltr_vpn_q  <= ltr_vpn_d;
         ltr_ppn_q  <= ltr_ppn_d;
         ltr_pcid_q <= ltr_pcid_d;
         rv_q       <= rv_d;
         rid_q      <= rid_d;
         rta_q      <= rta_d;
         rf_q       <= rf_d;
      end
   end

   assign req_ready    = grant ? (sel ? 2'b10 : 2'b01) : 2'b00;
   assign rsp_valid    = rv_q;
   assign rsp_id       = rid_q;
   assign rsp_ta       = rta_q;
   assign rsp_fault    = rf_q;
   assign flush_done   = (state_q == S_FWAIT);
   assign walk_req     = (state_q == S_WALK);
   assign walk_va      = va_q;
   assign walk_pcid    = pcid_q;
   assign tlb_va       = tva_q;
   assign tlb_pcid     = tpcid_q;
   assign tlb_pa       = tpa_q;
   assign tlb_insert   = (state_q == S_INSERT);
   assign tlb_shutdown = (state_q == S_FLUSH);

`ifdef TLB_REQ_CTRL_STATS_EN
   logic [31:0] hits_q, hits_d;
   logic [31:0] miss_q, miss_d;
   logic [31:0] flt_q, flt_d;
   logic        hit_ev, miss_ev, flt_ev;

   assign hit_ev  = ltr_hit || (state_q == S_LOOKUP && tlb_hit);
   assign miss_ev = (state_q == S_LOOKUP) && !tlb_hit &&
                    (tlb_miss || cnt_q == TO_LAST);
   assign flt_ev  = (state_q == S_WALK) && walk_ack && walk_fault;

   always_comb begin
      hits_d = hits_q;
      miss_d = miss_q;
      flt_d  = flt_q;
      if (flush_done) begin
         hits_d = '0;
         miss_d = '0;
         flt_d  = '0;
      end else begin
         if (hit_ev && !(&hits_q)) hits_d = hits_q + 32'd1;
         if (miss_ev && !(&miss_q)) miss_d = miss_q + 32'd1;
         if (flt_ev && !(&flt_q)) flt_d = flt_q + 32'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hits_q <= '0;
         miss_q <= '0;
         flt_q  <= '0;
      end else begin
         hits_q <= hits_d;
         miss_q <= miss_d;
         flt_q  <= flt_d;
      end
   end

   assign stat_hits   = hits_q;
   assign stat_misses = miss_q;
   assign stat_faults = flt_q;
`endif

endmodule

// File: doc/tlb_req_ctrl.md
Name: tlb_req_ctrl

Overview:
- Front-end controller that shares one TLB instance between two requesters (port 0 = instruction fetch, port 1 = data access) using round-robin arbitration.
- Sequences each lookup, tracks the TLB hit/miss result and, on a miss, runs a page-walk handshake.
- After the walk it force-inserts the resulting PTE into the TLB, then returns the translated address to the requester.
- Also sequences TLB flushes.

Parameters:
- SADDR, 64, address width.
- SPAGE, 12, page-offset width.
- SPCID, 12, PCID width.
- TIMEOUT, 4, cycles to wait for a TLB hit/miss before treating the lookup as a miss (range 2..15).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  2  per-port request valid.
- req_va  in  2*SADDR  per-port virtual address; port i at [i*SADDR +: SADDR].
- req_pcid  in  2*SPCID  per-port PCID; port i at [i*SPCID +: SPCID].
- req_ready  out  2  one-cycle accept pulse per port.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_id  out  1  port that owns the response.
- rsp_ta  out  SADDR  translated address.
- rsp_fault  out  1  page walk reported a fault; rsp_ta = 0.
- flush_req  in  1  level request to clear the TLB.
- flush_done  out  1  one-cycle pulse when the flush completes.
- walk_req  out  1  page-walk request (level, held until walk_ack).
- walk_va  out  SADDR  VA being walked.
- walk_pcid  out  SPCID  PCID being walked.
- walk_ack  in  1  walk result valid (single cycle).
- walk_pa  in  SADDR  physical page base from the walker.
- walk_fault  in  1  walk fault qualifier, sampled with walk_ack.
- tlb_va  out  SADDR  to TLB va.
- tlb_pcid  out  SPCID  to TLB pcid.
- tlb_pa  out  SADDR  to TLB pa.
- tlb_insert  out  1  to TLB insert.
- tlb_shutdown  out  1  to TLB shutdown.
- tlb_hit  in  1  from TLB hit.
- tlb_miss  in  1  from TLB miss.
- tlb_ta  in  SADDR  from TLB translated address.

Behaviour:
- Reset values:
  - State IDLE; round-robin pointer favours port 0.
  - All outputs 0; tlb_va/tlb_pcid 0.
  - Last-translation register invalid.
- States: IDLE, LOOKUP, WALK, INSERT, FLUSH, FLUSH_WAIT.
- IDLE:
  - flush_req has priority over requests: go to FLUSH.
  - Otherwise grant one valid port. If both are valid, grant the port not granted last; after reset port 0 wins.
  - On grant, pulse req_ready[i] and latch va/pcid/id.
  - Last-translation register: if the latched {va page, pcid} equals the register's {va page, pcid} and it is valid, respond next cycle with rsp_ta = {stored page, va offset} and stay in IDLE. This is required because the TLB does not re-look-up an unchanged va/pcid.
  - Otherwise drive tlb_va/tlb_pcid and enter LOOKUP with a zeroed counter.
- LOOKUP:
  - tlb_hit=1: rsp_valid with rsp_ta = tlb_ta, update the last-translation register, go to IDLE.
  - tlb_miss=1, or counter reaches TIMEOUT: go to WALK.
  - If hit and miss are both 1, hit wins.
- WALK:
  - Hold walk_req=1 with the latched va/pcid until walk_ack.
  - On ack with walk_fault: rsp_valid, rsp_fault=1, rsp_ta=0, no insert, go to IDLE.
  - On ack without fault: drive tlb_pa = walk_pa and go to INSERT.
- INSERT:
  - tlb_insert=1 for exactly 2 cycles. The TLB samples insert on one edge and acts on the next.
  - tlb_va/tlb_pcid stay stable throughout.
  - Then rsp_valid with rsp_ta = {walk_pa[SADDR-1:SPAGE], va[SPAGE-1:0]}, update the last-translation register, go to IDLE.
- FLUSH:
  - tlb_shutdown=1 for 2 cycles; invalidate the last-translation register.
  - Go to FLUSH_WAIT for 1 cycle, then pulse flush_done and return to IDLE.
  - flush_req arriving mid-transaction is deferred until the state returns to IDLE.
- Rules:
  - At most one outstanding transaction; req_ready never pulses outside IDLE.
  - Requesters hold req_valid/va/pcid until req_ready.
- rst_n assertion mid-walk: drop walk_req immediately (asynchronous) and discard the transaction; no response is produced.
- tlb_ta upper bits are used as-is; no width extension.

Optional Feature:
- Macro: TLB_REQ_CTRL_STATS_EN.
- When defined, adds outputs stat_hits[31:0], stat_misses[31:0] and stat_faults[31:0].
  - Last-translation-register hits count as hits.
  - Counters saturate at all-ones and reset to 0 on rst_n or flush_done.
- When undefined, these ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Reset then port 0 va=0x1234 pcid=1, tlb_miss, walk_ack with walk_pa=0xABC000 -> walk_req held until ack, tlb_insert high 2 cycles, rsp_ta=0xABC234, rsp_id=0.
- Repeat port 0 va=0x1FF0 pcid=1 -> no TLB lookup, response next cycle, rsp_ta=0xABCFF0.
- Both ports valid every cycle -> grants alternate 0,1,0,1; four responses with the matching rsp_id.
- Port 1 va=0x5000, walk_ack with walk_fault=1 -> rsp_fault=1, rsp_ta=0, tlb_insert never asserted.
- flush_req during WALK -> flush starts only after the response; tlb_shutdown high 2 cycles; flush_done pulses; the next identical VA goes to LOOKUP again.
- Lookup with TLB silent for 4 cycles -> walk_req asserts on the 5th cycle. With TLB_REQ_CTRL_STATS_EN defined: stat_misses increments by 1.
